// File: rtl/scancode_decoder_if.sv
// ---------------------------------------------------------------------------
// scancode_decoder_if
//   Decoded key event stream from the PS/2 scan-code decoder to its consumer.
//   The stream is first-word-fall-through: the head event fields are valid
//   while key_valid=1, and the consumer pops it by holding key_ready=1
//   across a rising clock edge.
//
//   key_code      decoder -> consumer  8  scan code (final byte of sequence)
//   key_break     decoder -> consumer  1  event is a key release
//   key_extended  decoder -> consumer  1  event is E0-prefixed, or Pause
//   key_valid     decoder -> consumer  1  head event fields are valid
//   key_ready     consumer -> decoder  1  consumer accepts the head event
// ---------------------------------------------------------------------------
interface scancode_decoder_if;
  logic [7:0] key_code;
  logic       key_break;
  logic       key_extended;
  logic       key_valid;
  logic       key_ready;

  modport master (
    output key_code,
    output key_break,
    output key_extended,
    output key_valid,
    input  key_ready
  );

  modport slave (
    input  key_code,
    input  key_break,
    input  key_extended,
    input  key_valid,
    output key_ready
  );
endinterface

// File: rtl/scancode_decoder.sv
// ---------------------------------------------------------------------------
// scancode_decoder
//   Turns the byte stream of a PS/2 keyboard receiver (scan code set 2) into
//   make/break key events, buffered in a small first-word-fall-through FIFO.
//   Device responses (ACK, BAT OK, errors) are reported as one-cycle pulses.
//
//   Parameters
//     FIFO_DEPTH        event FIFO depth (power of two, >= 2)
//   Ports
//     CLOCK_50          in   1  system clock, rising edge
//     reset             in   1  asynchronous active-low reset
//     received_data     in   8  byte from the PS/2 receiver
//     received_data_en  in   1  one-cycle strobe qualifying received_data
//     clear_overflow    in   1  clears the sticky overflow flag
//     key_bus           master modport of scancode_decoder_if (event stream)
//     dev_ack           out  1  pulse on byte FA
//     dev_bat_ok        out  1  pulse on byte AA
//     dev_error         out  1  pulse on byte 00, FC or FF
//     overflow          out  1  sticky: an event was dropped on a full FIFO
// ---------------------------------------------------------------------------
module scancode_decoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic [7:0]                received_data,
  input  logic                      received_data_en,
  input  logic                      clear_overflow,
  scancode_decoder_if.master        key_bus,
  output logic                      dev_ack,
  output logic                      dev_bat_ok,
  output logic                      dev_error,
  output logic                      overflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [7:0] BYTE_EXT   = 8'hE0;
  localparam logic [7:0] BYTE_BRK   = 8'hF0;
  localparam logic [7:0] BYTE_PAUSE = 8'hE1;
  localparam logic [7:0] BYTE_ACK   = 8'hFA;
  localparam logic [7:0] BYTE_BAT   = 8'hAA;
  localparam logic [7:0] BYTE_ERR0  = 8'h00;
  localparam logic [7:0] BYTE_ERR1  = 8'hFC;
  localparam logic [7:0] BYTE_ERR2  = 8'hFF;

  // Code reported for the Pause key once its E1 sequence has been skipped
  localparam logic [7:0] PAUSE_CODE = 8'h77;
  // Bytes following E1 in the Pause make sequence (E1 14 77 E1 F0 14 F0 77)
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_BRK     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_PAUSE   = 3'd4
  } state_t;

  // FIFO entry: {break, extended, code}
  typedef struct packed {
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } event_t;

  // -------------------------------------------------------------------------
  // Byte classification
  // -------------------------------------------------------------------------
  logic is_ctrl;
  logic is_ext;
  logic is_brk;
  logic is_pause;

  always_comb begin
    is_ctrl  = (received_data == BYTE_ACK)  || (received_data == BYTE_BAT)  ||
               (received_data == BYTE_ERR0) || (received_data == BYTE_ERR1) ||
               (received_data == BYTE_ERR2);
    is_ext   = (received_data == BYTE_EXT);
    is_brk   = (received_data == BYTE_BRK);
    is_pause = (received_data == BYTE_PAUSE);
  end

  // -------------------------------------------------------------------------
  // Decoder FSM: state register
  // -------------------------------------------------------------------------
  state_t     state_reg;
  state_t     state_next;
  logic [2:0] skip_reg;
  logic [2:0] skip_next;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      skip_reg  <= 3'd0;
    end else begin
      state_reg <= state_next;
      skip_reg  <= skip_next;
    end
  end

  // -------------------------------------------------------------------------
  // Decoder FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    skip_next  = skip_reg;
    if (received_data_en) begin
      case (state_reg)
        ST_IDLE: begin
          if (is_ctrl) begin
            state_next = ST_IDLE;
          end else if (is_ext) begin
            state_next = ST_EXT;
          end else if (is_brk) begin
            state_next = ST_BRK;
          end else if (is_pause) begin
            state_next = ST_PAUSE;
            skip_next  = PAUSE_SKIP;
          end else begin
            state_next = ST_IDLE;
          end
        end
        ST_EXT: begin
          if (is_ctrl) begin
            state_next = ST_IDLE;
          end else if (is_brk) begin
            state_next = ST_EXT_BRK;
          end else if (is_ext) begin
            state_next = ST_EXT;
          end else begin
            state_next = ST_IDLE;
          end
        end
        ST_BRK: begin
          if (is_ctrl) begin
            state_next = ST_IDLE;
          end else if (is_ext) begin
            state_next = ST_EXT_BRK;
          end else if (is_brk) begin
            state_next = ST_BRK;
          end else begin
            state_next = ST_IDLE;
          end
        end
        ST_EXT_BRK: begin
          if (is_ctrl) begin
            state_next = ST_IDLE;
          end else if (is_ext || is_brk) begin
            state_next = ST_EXT_BRK;
          end else begin
            state_next = ST_IDLE;
          end
        end
        ST_PAUSE: begin
          // Bytes are only counted here, never interpreted. A count of 0 can
          // only be reached by corruption; leave rather than wrap around.
          if (skip_reg <= 3'd1) begin
            state_next = ST_IDLE;
            skip_next  = 3'd0;
          end else begin
            skip_next  = skip_reg - 3'd1;
          end
        end
        default: begin
          state_next = ST_IDLE;
          skip_next  = 3'd0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Decoder FSM: output logic (event push request and device pulses)
  // -------------------------------------------------------------------------
  logic   push_req;
  event_t push_event;
  logic   dev_ack_next;
  logic   dev_bat_ok_next;
  logic   dev_error_next;

  always_comb begin
    push_req        = 1'b0;
    push_event      = '0;
    dev_ack_next    = 1'b0;
    dev_bat_ok_next = 1'b0;
    dev_error_next  = 1'b0;
    if (received_data_en) begin
      // Device responses are recognised in every state except while
      // skipping the Pause sequence.
      if (state_reg != ST_PAUSE) begin
        dev_ack_next    = (received_data == BYTE_ACK);
        dev_bat_ok_next = (received_data == BYTE_BAT);
        dev_error_next  = (received_data == BYTE_ERR0) ||
                          (received_data == BYTE_ERR1) ||
                          (received_data == BYTE_ERR2);
      end
      case (state_reg)
        ST_IDLE: begin
          if (!is_ctrl && !is_ext && !is_brk && !is_pause) begin
            push_req   = 1'b1;
            push_event = '{brk: 1'b0, ext: 1'b0, code: received_data};
          end
        end
        ST_EXT: begin
          if (!is_ctrl && !is_ext && !is_brk) begin
            push_req   = 1'b1;
            push_event = '{brk: 1'b0, ext: 1'b1, code: received_data};
          end
        end
        ST_BRK: begin
          if (!is_ctrl && !is_ext && !is_brk) begin
            push_req   = 1'b1;
            push_event = '{brk: 1'b1, ext: 1'b0, code: received_data};
          end
        end
        ST_EXT_BRK: begin
          if (!is_ctrl && !is_ext && !is_brk) begin
            push_req   = 1'b1;
            push_event = '{brk: 1'b1, ext: 1'b1, code: received_data};
          end
        end
        ST_PAUSE: begin
          if (skip_reg <= 3'd1) begin
            push_req   = 1'b1;
            push_event = '{brk: 1'b0, ext: 1'b1, code: PAUSE_CODE};
          end
        end
        default: begin
          push_req = 1'b0;
        end
      endcase
    end
  end

  // Device pulses are registered so they appear in the cycle after the strobe
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      dev_ack    <= 1'b0;
      dev_bat_ok <= 1'b0;
      dev_error  <= 1'b0;
    end else begin
      dev_ack    <= dev_ack_next;
      dev_bat_ok <= dev_bat_ok_next;
      dev_error  <= dev_error_next;
    end
  end

  // -------------------------------------------------------------------------
  // Event FIFO (first-word-fall-through)
  // -------------------------------------------------------------------------
  event_t           mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             fifo_full;
  logic             fifo_valid;
  logic             do_pop;
  logic             do_push;
  logic             drop;
  event_t           head;

  always_comb begin
    fifo_valid = (count_reg != '0);
    fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
    do_pop     = fifo_valid && key_bus.key_ready;
    // A pop in the same edge frees the slot, so a full FIFO still accepts.
    do_push    = push_req && (!fifo_full || do_pop);
    drop       = push_req && fifo_full && !do_pop;
  end

  // Storage carries no reset: entries are only observable through the
  // count, which reset clears.
  always_ff @(posedge CLOCK_50) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_event;
    end
  end

  // Pointers are exactly log2(FIFO_DEPTH) bits, so +1 wraps modulo depth.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // A drop wins over a simultaneous clear so no lost event goes unreported.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clear_overflow) begin
      overflow <= 1'b0;
    end
  end

  // Head fields are forced to zero while the FIFO is empty
  always_comb begin
    head                 = mem[rd_ptr_reg];
    key_bus.key_valid    = fifo_valid;
    key_bus.key_code     = fifo_valid ? head.code : 8'h00;
    key_bus.key_break    = fifo_valid ? head.brk  : 1'b0;
    key_bus.key_extended = fifo_valid ? head.ext  : 1'b0;
  end

endmodule

// File: tb/tb_scancode_decoder.sv
// ---------------------------------------------------------------------------
// tb_scancode_decoder
//   Self-checking bench for scancode_decoder (FIFO_DEPTH = 4). Expected events
//   are queued as bytes are sent; a monitor pops and compares each event the
//   decoder hands over. Scenario tasks add their own inline checks.
// ---------------------------------------------------------------------------
module tb_scancode_decoder;

  typedef struct packed {
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } ev_t;

  logic       clk;
  logic       reset;
  logic [7:0] received_data;
  logic       received_data_en;
  logic       clear_overflow;
  logic       dev_ack;
  logic       dev_bat_ok;
  logic       dev_error;
  logic       overflow;

  int vectors    = 0;
  int miscompares = 0;
  int pops       = 0;
  ev_t sb [$];

  scancode_decoder_if kbus ();

  scancode_decoder #(.FIFO_DEPTH(4)) dut (
    .CLOCK_50         (clk),
    .reset            (reset),
    .received_data    (received_data),
    .received_data_en (received_data_en),
    .clear_overflow   (clear_overflow),
    .key_bus          (kbus.master),
    .dev_ack          (dev_ack),
    .dev_bat_ok       (dev_bat_ok),
    .dev_error        (dev_error),
    .overflow         (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: a pop happens at the next rising edge whenever
  // key_valid and key_ready are both high; inputs only change at falling edges.
  always @(negedge clk) begin
    #1;
    if (reset && kbus.key_valid && kbus.key_ready) begin
      ev_t got;
      ev_t exp;
      got = '{code: kbus.key_code, brk: kbus.key_break, ext: kbus.key_extended};
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_event: got code=%02h brk=%0b ext=%0b, required none",
                 got.code, got.brk, got.ext);
      end else begin
        exp = sb.pop_front();
        pops++;
        if (got !== exp) begin
          miscompares++;
          $display("FAIL event_%0d: got code=%02h brk=%0b ext=%0b, required code=%02h brk=%0b ext=%0b",
                   pops, got.code, got.brk, got.ext, exp.code, exp.brk, exp.ext);
        end else begin
          $display("event %0d: code=%02h brk=%0b ext=%0b", pops, got.code, got.brk, got.ext);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one byte strobe; returns at the falling edge after the sampling edge
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    received_data    = b;
    received_data_en = 1'b1;
    @(negedge clk);
    received_data_en = 1'b0;
  endtask

  task automatic expect_ev(input logic [7:0] code, input logic brk, input logic ext);
    sb.push_back('{code: code, brk: brk, ext: ext});
  endtask

  // Bounded wait for the scoreboard to empty; then the FIFO must be empty too
  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #2;
    vectors++;
    if (sb.size() != 0 || kbus.key_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_drain: pending=%0d key_valid=%0b, required pending=0 key_valid=0",
               name, sb.size(), kbus.key_valid);
    end
  endtask

  task automatic test_reset();
    reset            = 1'b0;
    received_data    = 8'h00;
    received_data_en = 1'b0;
    clear_overflow   = 1'b0;
    kbus.key_ready   = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({kbus.key_valid, kbus.key_code, kbus.key_break, kbus.key_extended,
         dev_ack, dev_bat_ok, dev_error, overflow} !== 15'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got valid=%0b code=%02h brk=%0b ext=%0b ack=%0b bat=%0b err=%0b ovf=%0b, required all 0",
               kbus.key_valid, kbus.key_code, kbus.key_break, kbus.key_extended,
               dev_ack, dev_bat_ok, dev_error, overflow);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_make_break();
    kbus.key_ready = 1'b1;
    expect_ev(8'h1C, 1'b0, 1'b0);
    send_byte(8'h1C);
    vectors++;
    if (kbus.key_valid !== 1'b1 || kbus.key_code !== 8'h1C) begin
      miscompares++;
      $display("FAIL make_latency: got valid=%0b code=%02h, required valid=1 code=1c",
               kbus.key_valid, kbus.key_code);
    end
    send_byte(8'hF0);
    vectors++;
    if (kbus.key_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL break_prefix_no_event: got valid=%0b, required 0", kbus.key_valid);
    end
    expect_ev(8'h1C, 1'b1, 1'b0);
    send_byte(8'h1C);
    vectors++;
    if (kbus.key_valid !== 1'b1 || kbus.key_break !== 1'b1) begin
      miscompares++;
      $display("FAIL break_latency: got valid=%0b brk=%0b, required valid=1 brk=1",
               kbus.key_valid, kbus.key_break);
    end
    wait_drain("make_break");
  endtask

  task automatic test_extended();
    kbus.key_ready = 1'b1;
    expect_ev(8'h75, 1'b0, 1'b1);
    send_byte(8'hE0);
    send_byte(8'h75);
    expect_ev(8'h75, 1'b1, 1'b1);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    // Repeated prefixes collapse: E0 E0 F0 F0 E0 6B is one extended release
    expect_ev(8'h6B, 1'b1, 1'b1);
    send_byte(8'hE0);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'hF0);
    send_byte(8'hE0);
    send_byte(8'h6B);
    wait_drain("extended");
  endtask

  task automatic test_pause();
    logic [7:0] seq_a [8];
    logic [7:0] seq_b [8];
    seq_a = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    // Device-response bytes inside the skip window are just counted
    seq_b = '{8'hE1, 8'hFA, 8'hAA, 8'h00, 8'hFC, 8'hFF, 8'hE0, 8'h77};
    kbus.key_ready = 1'b1;
    for (int s = 0; s < 2; s++) begin
      expect_ev(8'h77, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) begin
        send_byte(s == 0 ? seq_a[i] : seq_b[i]);
        vectors++;
        if ({dev_ack, dev_bat_ok, dev_error} !== 3'b000 ||
            kbus.key_valid !== (i == 7)) begin
          miscompares++;
          $display("FAIL pause_seq%0d_byte%0d: got ack=%0b bat=%0b err=%0b valid=%0b, required pulses 0 valid=%0b",
                   s, i, dev_ack, dev_bat_ok, dev_error, kbus.key_valid, (i == 7));
        end
      end
    end
    wait_drain("pause");
  endtask

  task automatic test_overflow();
    logic [7:0] codes [5];
    codes = '{8'h15, 8'h16, 8'h1E, 8'h26, 8'h25};
    @(negedge clk);
    kbus.key_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) expect_ev(codes[i], 1'b0, 1'b0);
      send_byte(codes[i]);
    end
    vectors++;
    if (overflow !== 1'b1 || kbus.key_code !== 8'h15) begin
      miscompares++;
      $display("FAIL overflow_set: got ovf=%0b head=%02h, required ovf=1 head=15",
               overflow, kbus.key_code);
    end
    // Clear coinciding with another drop: the flag must stay set
    @(negedge clk);
    received_data    = 8'h2E;
    received_data_en = 1'b1;
    clear_overflow   = 1'b1;
    @(negedge clk);
    received_data_en = 1'b0;
    clear_overflow   = 1'b0;
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_clear_vs_drop: got %0b, required 1", overflow);
    end
    kbus.key_ready = 1'b1;
    wait_drain("overflow");
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_sticky: got %0b, required 1", overflow);
    end
    clear_overflow = 1'b1;
    @(negedge clk);
    clear_overflow = 1'b0;
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_clear: got %0b, required 0", overflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] codes [4];
    codes = '{8'h1A, 8'h22, 8'h21, 8'h2A};
    @(negedge clk);
    kbus.key_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_ev(codes[i], 1'b0, 1'b0);
      send_byte(codes[i]);
    end
    // Full FIFO: push and pop on the same edge
    expect_ev(8'h32, 1'b0, 1'b0);
    @(negedge clk);
    received_data    = 8'h32;
    received_data_en = 1'b1;
    kbus.key_ready   = 1'b1;
    @(negedge clk);
    received_data_en = 1'b0;
    vectors++;
    if (overflow !== 1'b0 || kbus.key_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL full_push_pop: got ovf=%0b valid=%0b, required ovf=0 valid=1",
               overflow, kbus.key_valid);
    end
    wait_drain("back_to_back");
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL full_push_pop_ovf: got %0b, required 0", overflow);
    end
  endtask

  task automatic test_control();
    logic [7:0] ctrl  [5];
    logic [2:0] pulse [5];
    ctrl  = '{8'hFA, 8'hAA, 8'h00, 8'hFC, 8'hFF};
    pulse = '{3'b100, 3'b010, 3'b001, 3'b001, 3'b001};
    kbus.key_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      // Each control byte follows a prefix, which it must discard
      send_byte(i[0] ? 8'hF0 : 8'hE0);
      send_byte(ctrl[i]);
      vectors++;
      if ({dev_ack, dev_bat_ok, dev_error} !== pulse[i] || kbus.key_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL control_%02h_pulse: got ack/bat/err=%03b valid=%0b, required %03b valid=0",
                 ctrl[i], {dev_ack, dev_bat_ok, dev_error}, kbus.key_valid, pulse[i]);
      end
      @(negedge clk);
      vectors++;
      if ({dev_ack, dev_bat_ok, dev_error} !== 3'b000) begin
        miscompares++;
        $display("FAIL control_%02h_one_cycle: got ack/bat/err=%03b, required 000",
                 ctrl[i], {dev_ack, dev_bat_ok, dev_error});
      end
      expect_ev(8'h1C, 1'b0, 1'b0);
      send_byte(8'h1C);
    end
    wait_drain("control");
  endtask

  task automatic test_reset_midseq();
    kbus.key_ready = 1'b1;
    // Reset in EXT_BRK
    send_byte(8'hE0);
    send_byte(8'hF0);
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    expect_ev(8'h74, 1'b0, 1'b0);
    send_byte(8'h74);
    wait_drain("reset_extbrk");
    // Reset in PAUSE
    send_byte(8'hE1);
    send_byte(8'h14);
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    expect_ev(8'h1C, 1'b0, 1'b0);
    send_byte(8'h1C);
    wait_drain("reset_pause");
    // Asynchronous assertion empties a non-empty FIFO without a clock edge
    @(negedge clk);
    kbus.key_ready = 1'b0;
    send_byte(8'h2B);
    send_byte(8'h00);
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (kbus.key_valid !== 1'b0 || kbus.key_code !== 8'h00 || dev_error !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got valid=%0b code=%02h err=%0b, required 0 00 0",
               kbus.key_valid, kbus.key_code, dev_error);
    end
    @(negedge clk);
    reset = 1'b1;
    wait_drain("async_reset");
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_extended();
    test_pause();
    test_overflow();
    test_back_to_back();
    test_control();
    test_reset_midseq();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/scancode_decoder.md
SCANCODE_DECODER -- requirements
Module: scancode_decoder

Interface
REQ-001 FIFO_DEPTH, 4, event FIFO depth; power of two, minimum 2.
REQ-002 CLOCK_50  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 forces reset state immediately.
REQ-004 received_data  input  8  byte from PS/2 receiver.
REQ-005 received_data_en  input  1  one-cycle strobe; received_data is valid in that cycle.
REQ-006 key_ready  input  1  consumer accepts the head event.
REQ-007 clear_overflow  input  1  clears overflow flag.
REQ-008 key_code  output  8  head event scan code (final byte of sequence).
REQ-009 key_break  output  1  head event is a release (F0-prefixed).
REQ-010 key_extended  output  1  head event is E0-prefixed, or is Pause.
REQ-011 key_valid  output  1  FIFO non-empty; head event fields are valid.
REQ-012 dev_ack  output  1  one-cycle pulse on byte 0xFA.
REQ-013 dev_bat_ok  output  1  one-cycle pulse on byte 0xAA.
REQ-014 dev_error  output  1  one-cycle pulse on byte 0x00, 0xFC or 0xFF.
REQ-015 overflow  output  1  sticky; an event was dropped because the FIFO was full.

Function
REQ-016 Bytes are sampled only in cycles with received_data_en=1; all other cycles leave the decoder FSM unchanged.
REQ-017 FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen), PAUSE (skipping the E1 sequence).
REQ-018 IDLE: 0xE0 -> EXT; 0xF0 -> BRK; 0xE1 -> PAUSE with skip counter = 7; any other non-control byte -> push {code, break=0, ext=0}, stay IDLE.
REQ-019 EXT: 0xF0 -> EXT_BRK; 0xE0 -> stay EXT; other non-control byte -> push {code, break=0, ext=1} -> IDLE.
REQ-020 BRK: non-control, non-prefix byte -> push {code, break=1, ext=0} -> IDLE; 0xE0 -> EXT_BRK; 0xF0 -> stay BRK.
REQ-021 EXT_BRK: non-control, non-prefix byte -> push {code, break=1, ext=1} -> IDLE; 0xE0 or 0xF0 -> stay EXT_BRK.
REQ-022 PAUSE: each byte decrements the skip counter, with no byte interpretation. When the counter reaches 0, push {0x77, break=0, ext=1} and go to IDLE.
REQ-023 Control bytes 0xFA, 0xAA, 0x00, 0xFC, 0xFF outside PAUSE:
  - pulse the matching dev_* output in the cycle after the strobe;
  - push no event;
  - discard any pending prefix (-> IDLE).
REQ-024 Latency: a pushed event is visible on key_valid/key_code exactly 1 cycle after the strobe of its final byte, when the FIFO was empty.
REQ-025 FIFO is first-word-fall-through; outputs show the head entry. When key_valid=0, key_code/key_break/key_extended = 0.
REQ-026 Pop occurs when key_valid=1 and key_ready=1 at a clock edge; key_ready with an empty FIFO has no effect.
REQ-027 Push and pop in the same cycle, FIFO full: both occur, occupancy unchanged, no overflow.
REQ-028 Push, FIFO full, no pop: new event dropped; existing entries unchanged; overflow set the next cycle.
REQ-029 overflow stays 1 until clear_overflow=1. A clear coinciding with a new drop leaves overflow=1.
REQ-030 Read/write pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Occupancy count is log2(FIFO_DEPTH)+1 bits.

Reset
REQ-031 Reset=0 applies asynchronously:
  - FSM -> IDLE, skip counter = 0, FIFO emptied (pointers and count = 0);
  - key_valid, key_code, key_break, key_extended, dev_ack, dev_bat_ok, dev_error, overflow = 0.
REQ-032 Reset asserted mid-sequence (e.g. in EXT_BRK or PAUSE) discards the partial sequence. The first byte after release is decoded from IDLE.
REQ-033 The block leaves reset on the first CLOCK_50 edge after reset returns to 1; it requires no synchronous release.

Verification
REQ-034 Bytes 1C, F0 1C, key_ready=1 -> two events: {1C,b0,e0} then {1C,b1,e0}, each 1 cycle after its final strobe.
REQ-035 Bytes E0 75, E0 F0 75 -> events {75,b0,e1} then {75,b1,e1}.
REQ-036 Bytes E1 14 77 E1 F0 14 F0 77 -> exactly one event {77,b0,e1}; no dev_* pulses.
REQ-037 key_ready=0, 5 make codes 15 16 1E 26 25 (FIFO_DEPTH=4):
  - first 4 codes retained in order; 25 dropped; overflow=1;
  - then key_ready=1 -> 4 pops in order; clear_overflow -> overflow=0.
REQ-038 FIFO full, key_ready=1, with a push in the same cycle -> no drop, overflow stays 0.
REQ-039 Bytes E0 then FA -> dev_ack pulse, no event. Then byte 1C -> {1C,b0,e0}. Reset pulse after E0 F0, then byte 74 -> {74,b0,e0}.
